// File: rtl/iomem_pkg.sv
// Shared types and constants for the PicoSoC iomem router.
package iomem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [7:0]  IOMEM_PAGE_DEFAULT = 8'h03;
   localparam logic [31:0] IOMEM_ERR_DATA     = 32'hDEAD_BEEF;
   localparam int unsigned SLOT_MSB           = 23;
   localparam int unsigned SLOT_LSB           = 20;

endpackage

// File: rtl/iomem_watchdog.sv
// WAIT-state timeout counter; only instantiated when IOMEM_TIMEOUT_EN is defined.
module iomem_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic resetn,
   input  logic load,
   input  logic enable,
   output logic expired
);

   localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);

   logic [W-1:0] cnt;

   // Loaded with TIMEOUT_CYCLES-1 so expiry is seen during the last allowed WAIT cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= W'(TIMEOUT_CYCLES - 1);
      end else if (enable && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign expired = enable && (cnt == '0);

endmodule

// File: rtl/iomem_router.sv
// Routes iomem page ADDR_PAGE to NUM_SLAVES peripheral slots, one transaction at a time.
// Optional timeout/error reporting is enabled with the IOMEM_TIMEOUT_EN macro.
module iomem_router
   import iomem_pkg::*;
#(
   parameter int unsigned NUM_SLAVES     = 4,
   parameter logic [7:0]  ADDR_PAGE      = IOMEM_PAGE_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     iomem_valid,
   output logic                     iomem_ready,
   input  logic [3:0]               iomem_wstrb,
   input  logic [31:0]              iomem_addr,
   input  logic [31:0]              iomem_wdata,
   output logic [31:0]              iomem_rdata,
   output logic [NUM_SLAVES-1:0]    s_valid,
   output logic [3:0]               s_wstrb,
   output logic [19:0]              s_addr,
   output logic [31:0]              s_wdata,
   input  logic [NUM_SLAVES-1:0]    s_ready,
   input  logic [32*NUM_SLAVES-1:0] s_rdata,
   output logic                     err_pulse
);

   if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_slaves
      $error("iomem_router: NUM_SLAVES must be 1..16");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("iomem_router: TIMEOUT_CYCLES must be 1..65535");
   end

   state_t                 state;
   logic [3:0]             slot_q;
   logic                   err_q;
   logic [3:0]             req_slot;
   logic                   req_hit;
   logic                   req_mapped;
   logic [NUM_SLAVES-1:0]  req_onehot;
   logic                   sel_ready;
   logic [31:0]            sel_rdata;
   logic                   wd_expired;

   assign req_slot   = iomem_addr[SLOT_MSB:SLOT_LSB];
   assign req_hit    = iomem_valid && !iomem_ready && (iomem_addr[31:24] == ADDR_PAGE);
   assign req_mapped = ({28'd0, req_slot} < NUM_SLAVES);

   // Slot muxing by comparison keeps indexing in range for any NUM_SLAVES.
   always_comb begin
      sel_ready  = 1'b0;
      sel_rdata  = '0;
      req_onehot = '0;
      for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
         if (slot_q == 4'(k)) begin
            sel_ready = s_ready[k];
            sel_rdata = s_rdata[32*k +: 32];
         end
         if (req_slot == 4'(k)) begin
            req_onehot[k] = 1'b1;
         end
      end
   end

`ifdef IOMEM_TIMEOUT_EN
   localparam bit ERR_EN = 1'b1;
   logic wd_load;
   assign wd_load = (state == IDLE) && req_hit && req_mapped;

   iomem_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .resetn  (resetn),
      .load    (wd_load),
      .enable  (state == WAIT),
      .expired (wd_expired)
   );
`else
   localparam bit ERR_EN = 1'b0;
   assign wd_expired = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         iomem_ready <= 1'b0;
         iomem_rdata <= '0;
         s_valid     <= '0;
         s_wstrb     <= '0;
         s_addr      <= '0;
         s_wdata     <= '0;
         slot_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         iomem_ready <= 1'b0;
         iomem_rdata <= '0;
         err_q       <= 1'b0;
         case (state)
            IDLE: begin
               if (req_hit) begin
                  s_wstrb <= iomem_wstrb;
                  s_addr  <= iomem_addr[19:0];
                  s_wdata <= iomem_wdata;
                  slot_q  <= req_slot;
                  if (req_mapped) begin
                     s_valid <= req_onehot;
                     state   <= WAIT;
                  end else begin
                     iomem_ready <= 1'b1;
                     err_q       <= ERR_EN;
                     state       <= RESP;
                  end
               end
            end
            WAIT: begin
               // Response is registered on the way into RESP, so RESP is the ready cycle.
               if (sel_ready) begin
                  s_valid     <= '0;
                  iomem_ready <= 1'b1;
                  iomem_rdata <= sel_rdata;
                  state       <= RESP;
               end else if (wd_expired) begin
                  s_valid     <= '0;
                  iomem_ready <= 1'b1;
                  iomem_rdata <= IOMEM_ERR_DATA;
                  err_q       <= ERR_EN;
                  state       <= RESP;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign err_pulse = err_q;

endmodule

// File: tb/tb_iomem_router.sv
// Scoreboard bench for iomem_router (NUM_SLAVES=4, TIMEOUT_CYCLES=16); honours IOMEM_TIMEOUT_EN.
module tb_iomem_router;

   localparam int unsigned NS = 4;
   localparam int unsigned TO = 16;
`ifdef IOMEM_TIMEOUT_EN
   localparam logic ERR_ON = 1'b1;
`else
   localparam logic ERR_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic              iomem_valid = 1'b0;
   logic              iomem_ready;
   logic [3:0]        iomem_wstrb = '0;
   logic [31:0]       iomem_addr = '0;
   logic [31:0]       iomem_wdata = '0;
   logic [31:0]       iomem_rdata;
   logic [NS-1:0]     s_valid;
   logic [3:0]        s_wstrb;
   logic [19:0]       s_addr;
   logic [31:0]       s_wdata;
   logic [NS-1:0]     s_ready;
   logic [NS*32-1:0]  s_rdata;
   logic              err_pulse;

   iomem_router #(
      .NUM_SLAVES     (NS),
      .ADDR_PAGE      (8'h03),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .iomem_valid (iomem_valid),
      .iomem_ready (iomem_ready),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_rdata (iomem_rdata),
      .s_valid     (s_valid),
      .s_wstrb     (s_wstrb),
      .s_addr      (s_addr),
      .s_wdata     (s_wdata),
      .s_ready     (s_ready),
      .s_rdata     (s_rdata),
      .err_pulse   (err_pulse)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Slave model: slot k answers slv_delay[k] cycles after its strobe rises, unless silent.
   int unsigned slv_delay [NS] = '{0, 3, 0, 1};
   logic        slv_silent[NS] = '{1'b0, 1'b0, 1'b1, 1'b0};
   logic [31:0] slv_data  [NS] = '{32'h1234_5678, 32'hCAFE_0001, 32'h2222_0002, 32'h3333_0003};
   int unsigned slv_cnt   [NS] = '{0, 0, 0, 0};
   logic [NS-1:0] extra_ready = '0;

   always @(posedge clk) begin
      for (int k = 0; k < NS; k++) slv_cnt[k] <= s_valid[k] ? slv_cnt[k] + 1 : 0;
   end

   always_comb begin
      s_ready = '0;
      s_rdata = '0;
      for (int k = 0; k < NS; k++) begin
         s_ready[k] = (s_valid[k] && !slv_silent[k] && (slv_cnt[k] >= slv_delay[k])) || extra_ready[k];
         s_rdata[32*k +: 32] = slv_data[k];
      end
   end

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
   endtask

   typedef struct {
      int unsigned cyc;
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t sb[$];

   // Monitor: every iomem_ready pulse must match the oldest expected response.
   initial begin
      exp_t e;
      logic prev_rdy;
      prev_rdy = 1'b0;
      forever begin
         @(negedge clk);
         if (iomem_ready === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("ready_cycle", cyc, e.cyc);
               chk("rdata", iomem_rdata, e.rdata);
               chk("err_pulse", {31'd0, err_pulse}, {31'd0, e.err});
            end
         end else if (prev_rdy) begin
            chk("rdata_after_ready", iomem_rdata, 32'd0);
            chk("err_after_ready", {31'd0, err_pulse}, 32'd0);
         end
         prev_rdy = iomem_ready;
      end
   end

   task automatic do_req(input string nm, input logic [31:0] addr, input logic [3:0] ws,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input int unsigned lat,
                         input logic [NS-1:0] exp_sv, input logic exp_err);
      int unsigned c0;
      logic sv_ok, got;
      logic [NS-1:0] bad_sv;
      exp_t e;
      @(negedge clk);
      iomem_valid = 1'b1;
      iomem_addr  = addr;
      iomem_wstrb = ws;
      iomem_wdata = wd;
      c0 = cyc;
      e.cyc = c0 + lat; e.rdata = exp_rd; e.err = exp_err;
      sb.push_back(e);
      sv_ok = 1'b1; got = 1'b0; bad_sv = '0;
      for (int unsigned k = 1; k <= lat + 4 && !got; k++) begin
         @(negedge clk);
         if (s_valid !== ((k < lat) ? exp_sv : '0)) begin
            sv_ok = 1'b0;
            bad_sv = s_valid;
         end
         if (k == 1 && exp_sv != '0) begin
            chk({nm, "_s_addr"}, {12'd0, s_addr}, {12'd0, addr[19:0]});
            chk({nm, "_s_wdata"}, s_wdata, wd);
            chk({nm, "_s_wstrb"}, {28'd0, s_wstrb}, {28'd0, ws});
         end
         if (iomem_ready === 1'b1) got = 1'b1;
      end
      iomem_valid = 1'b0;
      chk({nm, "_ready_seen"}, {31'd0, got}, 32'd1);
      chk({nm, "_s_valid_window"}, sv_ok ? 32'd0 : {28'd0, bad_sv}, 32'd0);
   endtask

   // Holds a request for ncyc cycles expecting no response and a constant s_valid.
   task automatic hold_req(input string nm, input logic [31:0] addr, input int unsigned ncyc,
                           input logic [NS-1:0] exp_sv, input logic keep);
      logic sv_ok, rdy_seen;
      logic [NS-1:0] bad_sv;
      @(negedge clk);
      iomem_valid = 1'b1;
      iomem_addr  = addr;
      iomem_wstrb = 4'h0;
      sv_ok = 1'b1; rdy_seen = 1'b0; bad_sv = '0;
      for (int unsigned k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         if (s_valid !== exp_sv) begin
            sv_ok = 1'b0;
            bad_sv = s_valid;
         end
         if (iomem_ready !== 1'b0) rdy_seen = 1'b1;
      end
      if (!keep) iomem_valid = 1'b0;
      chk({nm, "_no_ready"}, {31'd0, rdy_seen}, 32'd0);
      chk({nm, "_s_valid"}, sv_ok ? {28'd0, exp_sv} : {28'd0, bad_sv}, {28'd0, exp_sv});
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish (cycle %0d)", cyc);
      $fatal(1, "global timeout");
   end

   initial begin
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, iomem_ready}, 32'd0);
      chk("rst_rdata", iomem_rdata, 32'd0);
      chk("rst_s_valid", {28'd0, s_valid}, 32'd0);
      chk("rst_s_addr", {12'd0, s_addr}, 32'd0);
      chk("rst_s_wdata", s_wdata, 32'd0);
      chk("rst_s_wstrb", {28'd0, s_wstrb}, 32'd0);
      chk("rst_err", {31'd0, err_pulse}, 32'd0);
      resetn = 1'b1;

      do_req("t1_write", 32'h0310_0004, 4'hF, 32'h0000_00A5, 32'hCAFE_0001, 5, 4'b0010, 1'b0);
      do_req("t2_read", 32'h0300_0000, 4'h0, 32'h0, 32'h1234_5678, 2, 4'b0001, 1'b0);
      do_req("b2b_slot3", 32'h0330_0010, 4'h0, 32'h0, 32'h3333_0003, 3, 4'b1000, 1'b0);

      extra_ready = 4'b1101;
      do_req("other_ready_ignored", 32'h0310_0008, 4'h3, 32'h0000_BEEF, 32'hCAFE_0001, 5, 4'b0010, 1'b0);
      extra_ready = 4'b0000;

      do_req("t3_unmapped", 32'h0370_0000, 4'h0, 32'h0, 32'h0, 1, 4'b0000, ERR_ON);
      do_req("slot15_unmapped", 32'h03F0_0008, 4'h1, 32'h55, 32'h0, 1, 4'b0000, ERR_ON);

      hold_req("t4_other_page", 32'h0200_0000, 20, 4'b0000, 1'b0);

`ifdef IOMEM_TIMEOUT_EN
      do_req("t5_timeout", 32'h0320_0000, 4'h0, 32'h0, 32'hDEAD_BEEF, TO + 1, 4'b0100, 1'b1);
      hold_req("t6_pre", 32'h0320_0000, 5, 4'b0100, 1'b1);
`else
      hold_req("t5_no_timeout", 32'h0320_0000, 100, 4'b0100, 1'b1);
`endif

      // Async reset between edges while slot 2 is still strobed.
      @(posedge clk);
      #2;
      resetn = 1'b0;
      #1;
      chk("t6_async_s_valid", {28'd0, s_valid}, 32'd0);
      chk("t6_async_ready", {31'd0, iomem_ready}, 32'd0);
      iomem_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1;

      do_req("t6_t2_again", 32'h0300_0000, 4'h0, 32'h0, 32'h1234_5678, 2, 4'b0001, 1'b0);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
